// File: rtl/alu_pkg.sv
// alu_pkg
// Shared definitions for the ALU issue path:
//   - alu_op_t     : 4-bit ALU operation code. Bit3 inverts src1, bit2 inverts
//                    src2 and forces carry-in, bits[1:0] pick AND/OR/ADD/SLT.
//   - OP_* / FN_*  : MIPS opcode and R-type funct values understood here.
//   - issue_uop_t  : one decoded micro-op as it sits in the issue buffer.
//   - sign_ext16 / zero_ext16 : immediate widening helpers.
package alu_pkg;

  localparam int UOP_XLEN = 32;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_NOR = 4'b1100
  } alu_op_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  typedef struct packed {
    alu_op_t               alu_op;
    logic [UOP_XLEN-1:0]   src1;
    logic [UOP_XLEN-1:0]   src2;
    logic                  ovf_en;
    logic                  illegal;
  } issue_uop_t;

  function automatic logic [UOP_XLEN-1:0] sign_ext16(input logic [15:0] imm);
    return {{(UOP_XLEN-16){imm[15]}}, imm};
  endfunction

  function automatic logic [UOP_XLEN-1:0] zero_ext16(input logic [15:0] imm);
    return {{(UOP_XLEN-16){1'b0}}, imm};
  endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// alu_ctrl_decode
// Purely combinational decode of a MIPS instruction into an issue micro-op.
// Ports:
//   opcode  : instruction[31:26]
//   funct   : instruction[5:0], only meaningful for R-type
//   imm16   : instruction[15:0]
//   rs_data : rs register value, always becomes src1
//   rt_data : rt register value, default src2
//   uop     : decoded micro-op {alu_op, src1, src2, ovf_en, illegal}
module alu_ctrl_decode
  import alu_pkg::*;
(
  input  logic [5:0]          opcode,
  input  logic [5:0]          funct,
  input  logic [15:0]         imm16,
  input  logic [UOP_XLEN-1:0] rs_data,
  input  logic [UOP_XLEN-1:0] rt_data,
  output issue_uop_t          uop
);

  // Start from the "undecodable" shape (ADD, src2 = rt, no trap) and let each
  // recognised encoding override only what differs. Unknown encodings keep
  // that shape with illegal set, so they still flow down the pipe and the
  // trap is raised where the op is consumed.
  always_comb begin
    uop         = '0;
    uop.alu_op  = ALU_ADD;
    uop.src1    = rs_data;
    uop.src2    = rt_data;
    uop.ovf_en  = 1'b0;
    uop.illegal = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  begin uop.alu_op = ALU_ADD; uop.ovf_en = 1'b1; end
          FN_ADDU: uop.alu_op = ALU_ADD;
          FN_SUB:  begin uop.alu_op = ALU_SUB; uop.ovf_en = 1'b1; end
          FN_SUBU: uop.alu_op = ALU_SUB;
          FN_AND:  uop.alu_op = ALU_AND;
          FN_OR:   uop.alu_op = ALU_OR;
          FN_NOR:  uop.alu_op = ALU_NOR;
          FN_SLT:  uop.alu_op = ALU_SLT;
          default: uop.illegal = 1'b1;
        endcase
      end
      OP_ADDI: begin
        uop.alu_op = ALU_ADD;
        uop.src2   = sign_ext16(imm16);
        uop.ovf_en = 1'b1;
      end
      OP_ADDIU, OP_LW, OP_SW: begin
        uop.alu_op = ALU_ADD;
        uop.src2   = sign_ext16(imm16);
      end
      OP_SLTI: begin
        uop.alu_op = ALU_SLT;
        uop.src2   = sign_ext16(imm16);
      end
      // Logical immediates are zero-extended, unlike the arithmetic ones.
      OP_ANDI: begin
        uop.alu_op = ALU_AND;
        uop.src2   = zero_ext16(imm16);
      end
      OP_ORI: begin
        uop.alu_op = ALU_OR;
        uop.src2   = zero_ext16(imm16);
      end
      // Branch compare: subtract rt from rs, result feeds the zero flag.
      OP_BEQ, OP_BNE: uop.alu_op = ALU_SUB;
      default: uop.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_buffer.sv
// alu_issue_buffer
// Decodes incoming instructions and queues the resulting micro-ops in a
// DEPTH-entry FIFO feeding the combinational ALU.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid / in_ready : upstream handshake (in_ready is registered !full)
//   opcode, funct, imm16, rs_data, rt_data : instruction fields and operands
//   flush               : drop everything queued plus this cycle's input
//   out_valid / out_ready : downstream handshake on the head entry
//   alu_op, alu_src1, alu_src2, ovf_en, illegal : head micro-op, zero when empty
// XLEN must match alu_pkg::UOP_XLEN, since the queued struct is sized by it.
module alu_issue_buffer
  import alu_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int XLEN  = UOP_XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [5:0]      opcode,
  input  logic [5:0]      funct,
  input  logic [15:0]     imm16,
  input  logic [XLEN-1:0] rs_data,
  input  logic [XLEN-1:0] rt_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      alu_op,
  output logic [XLEN-1:0] alu_src1,
  output logic [XLEN-1:0] alu_src2,
  output logic            ovf_en,
  output logic            illegal
);

  localparam int         PW         = $clog2(DEPTH);
  localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

  issue_uop_t     dec_uop;
  issue_uop_t     mem [DEPTH];
  issue_uop_t     head;
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [PW:0]    count;
  logic [PW:0]    count_next;
  logic           push;
  logic           pop;

  alu_ctrl_decode u_decode (
    .opcode  (opcode),
    .funct   (funct),
    .imm16   (imm16),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .uop     (dec_uop)
  );

  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready;
  assign out_valid = (count != '0);

  // Occupancy after this cycle's push/pop; a simultaneous push and pop
  // leaves it unchanged. Used both for count and the registered in_ready.
  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + (PW+1)'(1);
      2'b01:   count_next = count - (PW+1)'(1);
      default: count_next = count;
    endcase
  end

  // Pointer/count/ready state. Flush wins over any push or pop in the same
  // cycle; the head popped during a flush cycle is still taken downstream,
  // we simply forget everything afterwards. in_ready is kept as a flop so
  // the upstream stage sees a clean registered signal.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      in_ready <= 1'b1;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      in_ready <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count    <= count_next;
      in_ready <= (count_next != FULL_COUNT);
    end
  end

  // Entry storage carries no reset; validity is tracked purely by count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= dec_uop;
  end

  // Head outputs are forced to zero whenever the buffer is empty so the ALU
  // never sees stale operands from an already-consumed entry.
  assign head     = mem[rd_ptr];
  assign alu_op   = out_valid ? 4'(head.alu_op) : 4'b0;
  assign alu_src1 = out_valid ? head.src1 : '0;
  assign alu_src2 = out_valid ? head.src2 : '0;
  assign ovf_en   = out_valid && head.ovf_en;
  assign illegal  = out_valid && head.illegal;

endmodule

// File: tb/tb_alu_issue_buffer.sv
// tb_alu_issue_buffer
// Self-checking bench for alu_issue_buffer: a directed decode table, a few
// hand-built multi-cycle sequences (full, flush, async reset) and a random
// phase, all compared every cycle against a queue-based reference model.
module tb_alu_issue_buffer;

  localparam int DEPTH = 2;
  localparam int XLEN  = 32;

  logic            clk;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [5:0]      opcode;
  logic [5:0]      funct;
  logic [15:0]     imm16;
  logic [XLEN-1:0] rs_data;
  logic [XLEN-1:0] rt_data;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [3:0]      alu_op;
  logic [XLEN-1:0] alu_src1;
  logic [XLEN-1:0] alu_src2;
  logic            ovf_en;
  logic            illegal;

  alu_issue_buffer #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .funct     (funct),
    .imm16     (imm16),
    .rs_data   (rs_data),
    .rt_data   (rt_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_op    (alu_op),
    .alu_src1  (alu_src1),
    .alu_src2  (alu_src2),
    .ovf_en    (ovf_en),
    .illegal   (illegal)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] s1;
    logic [31:0] s2;
    logic        ovf;
    logic        ill;
  } model_uop_t;

  typedef struct {
    logic [5:0]  opc;
    logic [5:0]  fn;
    logic [15:0] imm;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [3:0]  exp_op;
    logic [31:0] exp_s2;
    logic        exp_ovf;
    logic        exp_ill;
  } vec_t;

  model_uop_t model_q[$];
  vec_t       vecs[19];
  int         n_checks = 0;
  int         n_fail   = 0;

  // Reference decode straight from the instruction table: pick the operation
  // name, then the operand source, then widen the immediate arithmetically.
  function automatic model_uop_t ref_decode(input logic [5:0] opc, input logic [5:0] fn,
                                            input logic [15:0] imm, input logic [31:0] rs,
                                            input logic [31:0] rt);
    model_uop_t u;
    int         simm;
    simm  = (imm >= 16'h8000) ? int'(imm) - 65536 : int'(imm);
    u.op  = 4'b0010;
    u.s1  = rs;
    u.s2  = rt;
    u.ovf = 1'b0;
    u.ill = 1'b0;
    if (opc == 6'h00) begin
      if      (fn == 6'h20) begin u.op = 4'b0010; u.ovf = 1'b1; end
      else if (fn == 6'h21) u.op = 4'b0010;
      else if (fn == 6'h22) begin u.op = 4'b0110; u.ovf = 1'b1; end
      else if (fn == 6'h23) u.op = 4'b0110;
      else if (fn == 6'h24) u.op = 4'b0000;
      else if (fn == 6'h25) u.op = 4'b0001;
      else if (fn == 6'h27) u.op = 4'b1100;
      else if (fn == 6'h2A) u.op = 4'b0111;
      else u.ill = 1'b1;
    end else if (opc == 6'h08 || opc == 6'h09 || opc == 6'h23 || opc == 6'h2B) begin
      u.op  = 4'b0010;
      u.s2  = 32'(simm);
      u.ovf = (opc == 6'h08);
    end else if (opc == 6'h0A) begin
      u.op = 4'b0111;
      u.s2 = 32'(simm);
    end else if (opc == 6'h0C || opc == 6'h0D) begin
      u.op = (opc == 6'h0C) ? 4'b0000 : 4'b0001;
      u.s2 = 32'(int'(imm));
    end else if (opc == 6'h04 || opc == 6'h05) begin
      u.op = 4'b0110;
    end else begin
      u.ill = 1'b1;
    end
    return u;
  endfunction

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every DUT output against the head of the model queue.
  task automatic check_output();
    model_uop_t h;
    logic       v;
    v = (model_q.size() != 0);
    h = '{op: 4'b0, s1: 32'b0, s2: 32'b0, ovf: 1'b0, ill: 1'b0};
    if (v) h = model_q[0];
    check_val("out_valid", 32'(out_valid), 32'(v));
    check_val("in_ready",  32'(in_ready),  32'(model_q.size() < DEPTH));
    check_val("alu_op",    32'(alu_op),    32'(h.op));
    check_val("alu_src1",  alu_src1,       h.s1);
    check_val("alu_src2",  alu_src2,       h.s2);
    check_val("ovf_en",    32'(ovf_en),    32'(h.ovf));
    check_val("illegal",   32'(illegal),   32'(h.ill));
  endtask

  task automatic apply_stimulus(input logic iv, input logic [5:0] opc, input logic [5:0] fn,
                                input logic [15:0] imm, input logic [31:0] rs,
                                input logic [31:0] rt, input logic fl, input logic ordy);
    in_valid  = iv;
    opcode    = opc;
    funct     = fn;
    imm16     = imm;
    rs_data   = rs;
    rt_data   = rt;
    flush     = fl;
    out_ready = ordy;
  endtask

  // Advance one clock: the model decides push/pop from its own occupancy,
  // updates after the edge, then the outputs are checked 1 ns later.
  task automatic tick();
    logic       do_push;
    logic       do_pop;
    model_uop_t u;
    do_push = in_valid && (model_q.size() < DEPTH) && !flush;
    do_pop  = (model_q.size() != 0) && out_ready;
    u       = ref_decode(opcode, funct, imm16, rs_data, rt_data);
    @(posedge clk);
    #1;
    if (flush) begin
      model_q.delete();
    end else begin
      if (do_pop)  void'(model_q.pop_front());
      if (do_push) model_q.push_back(u);
    end
    check_output();
  endtask

  task automatic idle();
    apply_stimulus(1'b0, 6'h00, 6'h00, 16'h0, 32'h0, 32'h0, 1'b0, 1'b1);
  endtask

  initial begin
    // opcode, funct, imm16, rs, rt, expected alu_op, src2, ovf_en, illegal
    vecs[0]  = '{6'h00, 6'h20, 16'h1234, 32'd5,        32'd3,        4'b0010, 32'd3,        1'b1, 1'b0};
    vecs[1]  = '{6'h00, 6'h21, 16'h0000, 32'd7,        32'd9,        4'b0010, 32'd9,        1'b0, 1'b0};
    vecs[2]  = '{6'h00, 6'h22, 16'hFFFF, 32'h10,       32'h20,       4'b0110, 32'h20,       1'b1, 1'b0};
    vecs[3]  = '{6'h00, 6'h23, 16'h0001, 32'h11,       32'h22,       4'b0110, 32'h22,       1'b0, 1'b0};
    vecs[4]  = '{6'h00, 6'h24, 16'h0002, 32'hF0F0F0F0, 32'h0FF00FF0, 4'b0000, 32'h0FF00FF0, 1'b0, 1'b0};
    vecs[5]  = '{6'h00, 6'h25, 16'h0003, 32'h1,        32'h2,        4'b0001, 32'h2,        1'b0, 1'b0};
    vecs[6]  = '{6'h00, 6'h27, 16'h0004, 32'h3,        32'h4,        4'b1100, 32'h4,        1'b0, 1'b0};
    vecs[7]  = '{6'h00, 6'h2A, 16'h0005, 32'h5,        32'h6,        4'b0111, 32'h6,        1'b0, 1'b0};
    vecs[8]  = '{6'h08, 6'h20, 16'h8000, 32'h100,      32'hDEAD,     4'b0010, 32'hFFFF8000, 1'b1, 1'b0};
    vecs[9]  = '{6'h09, 6'h00, 16'hFFFF, 32'h200,      32'hBEEF,     4'b0010, 32'hFFFFFFFF, 1'b0, 1'b0};
    vecs[10] = '{6'h0A, 6'h2A, 16'h0005, 32'h300,      32'h1,        4'b0111, 32'h00000005, 1'b0, 1'b0};
    vecs[11] = '{6'h0C, 6'h00, 16'hFFFF, 32'h400,      32'h2,        4'b0000, 32'h0000FFFF, 1'b0, 1'b0};
    vecs[12] = '{6'h0D, 6'h00, 16'h8001, 32'h500,      32'h3,        4'b0001, 32'h00008001, 1'b0, 1'b0};
    vecs[13] = '{6'h23, 6'h00, 16'hFFFC, 32'h600,      32'h4,        4'b0010, 32'hFFFFFFFC, 1'b0, 1'b0};
    vecs[14] = '{6'h2B, 6'h00, 16'h0010, 32'h700,      32'h5,        4'b0010, 32'h00000010, 1'b0, 1'b0};
    vecs[15] = '{6'h04, 6'h00, 16'h1234, 32'h800,      32'hAA,       4'b0110, 32'hAA,       1'b0, 1'b0};
    vecs[16] = '{6'h05, 6'h00, 16'h4321, 32'h900,      32'hBB,       4'b0110, 32'hBB,       1'b0, 1'b0};
    vecs[17] = '{6'h3F, 6'h20, 16'hFFFF, 32'hA00,      32'h11,       4'b0010, 32'h11,       1'b0, 1'b1};
    vecs[18] = '{6'h00, 6'h26, 16'h7777, 32'hB00,      32'h22,       4'b0010, 32'h22,       1'b0, 1'b1};

    rst = 1'b1;
    idle();
    #22;
    // Reset state while rst is still held
    check_output();
    rst = 1'b0;
    tick();

    // Directed decode table: push, see it next cycle, it pops, then empty.
    for (int i = 0; i < 19; i++) begin
      apply_stimulus(1'b1, vecs[i].opc, vecs[i].fn, vecs[i].imm, vecs[i].rs, vecs[i].rt, 1'b0, 1'b1);
      tick();
      check_val($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
      check_val($sformatf("vec%0d_op", i),    32'(alu_op),    32'(vecs[i].exp_op));
      check_val($sformatf("vec%0d_src1", i),  alu_src1,       vecs[i].rs);
      check_val($sformatf("vec%0d_src2", i),  alu_src2,       vecs[i].exp_s2);
      check_val($sformatf("vec%0d_ovf", i),   32'(ovf_en),    32'(vecs[i].exp_ovf));
      check_val($sformatf("vec%0d_ill", i),   32'(illegal),   32'(vecs[i].exp_ill));
      idle();
      tick();
      check_val($sformatf("vec%0d_drained", i), 32'(out_valid), 32'd0);
    end

    // Fill with nor then slt while stalled, try a third push, then drain.
    apply_stimulus(1'b1, 6'h00, 6'h27, 16'h0, 32'h31, 32'h32, 1'b0, 1'b0);
    tick();
    apply_stimulus(1'b1, 6'h00, 6'h2A, 16'h0, 32'h41, 32'h42, 1'b0, 1'b0);
    tick();
    check_val("full_in_ready", 32'(in_ready), 32'd0);
    apply_stimulus(1'b1, 6'h00, 6'h20, 16'h0, 32'h51, 32'h52, 1'b0, 1'b0);
    tick();
    check_val("full_head_held", 32'(alu_op), 32'(4'b1100));
    apply_stimulus(1'b0, 6'h00, 6'h00, 16'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    tick();
    check_val("drain_second_op", 32'(alu_op), 32'(4'b0111));
    check_val("drain_ready_back", 32'(in_ready), 32'd1);
    tick();
    check_val("drain_empty", 32'(out_valid), 32'd0);

    // Flush with a full buffer and a valid incoming op.
    apply_stimulus(1'b1, 6'h00, 6'h24, 16'h0, 32'h61, 32'h62, 1'b0, 1'b0);
    tick();
    apply_stimulus(1'b1, 6'h00, 6'h25, 16'h0, 32'h71, 32'h72, 1'b0, 1'b0);
    tick();
    apply_stimulus(1'b1, 6'h00, 6'h21, 16'h0, 32'h81, 32'h82, 1'b1, 1'b1);
    tick();
    check_val("flush_valid", 32'(out_valid), 32'd0);
    check_val("flush_ready", 32'(in_ready), 32'd1);
    idle();
    tick();
    check_val("flush_no_enqueue", 32'(out_valid), 32'd0);

    // Asynchronous reset mid-cycle with one entry queued.
    apply_stimulus(1'b1, 6'h0D, 6'h00, 16'hABCD, 32'h91, 32'h92, 1'b0, 1'b0);
    tick();
    apply_stimulus(1'b0, 6'h00, 6'h00, 16'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    model_q.delete();
    check_output();
    #2;
    rst = 1'b0;
    idle();
    tick();

    // Random phase against the model.
    for (int c = 0; c < 400; c++) begin
      logic [5:0] opc;
      logic [5:0] fn;
      case ($urandom_range(0, 10))
        0:  opc = 6'h08;
        1:  opc = 6'h09;
        2:  opc = 6'h0A;
        3:  opc = 6'h0C;
        4:  opc = 6'h0D;
        5:  opc = 6'h23;
        6:  opc = 6'h2B;
        7:  opc = 6'h04;
        8:  opc = 6'h05;
        9:  opc = 6'($urandom);
        default: opc = 6'h00;
      endcase
      case ($urandom_range(0, 8))
        0: fn = 6'h20;
        1: fn = 6'h21;
        2: fn = 6'h22;
        3: fn = 6'h23;
        4: fn = 6'h24;
        5: fn = 6'h25;
        6: fn = 6'h27;
        7: fn = 6'h2A;
        default: fn = 6'($urandom);
      endcase
      apply_stimulus(1'($urandom_range(0, 3) != 0), opc, fn, 16'($urandom), $urandom, $urandom,
                     1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 2) != 0));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_issue_buffer.md
Name: alu_issue_buffer

Overview:
- Issue side of the ALU operation interface: decodes MIPS opcode/funct into the 4-bit ALU operation code (bit3 invert src1; bit2 invert src2 plus carry-in 1; bits[1:0] select AND/OR/ADD/SLT).
- Selects src2 as register, sign-extended immediate or zero-extended immediate.
- Queues decoded micro-ops in a small FIFO with valid/ready handshake on both sides.
- Sits between the register-read stage and the combinational ALU in the execute stage.

Parameters:
- DEPTH, 2, FIFO entries; power of two, at least 2.
- XLEN, 32, operand width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream holds a valid instruction.
- in_ready  out  1  buffer accepts this cycle; equals !full, registered.
- opcode  in  6  instruction[31:26].
- funct  in  6  instruction[5:0].
- imm16  in  16  instruction[15:0].
- rs_data  in  XLEN  rs register value.
- rt_data  in  XLEN  rt register value.
- flush  in  1  discard all queued and incoming ops (branch redirect).
- out_valid  out  1  head entry is valid.
- out_ready  in  1  execute stage consumes head.
- alu_op  out  4  ALU operation code of head.
- alu_src1  out  XLEN  first operand of head.
- alu_src2  out  XLEN  second operand of head.
- ovf_en  out  1  overflow trap enabled for head (signed add/sub).
- illegal  out  1  head instruction not decodable.

Behaviour:
- ALU operation codes:
  - AND = 4'b0000
  - OR = 4'b0001
  - ADD = 4'b0010
  - SUB = 4'b0110
  - SLT = 4'b0111
  - NOR = 4'b1100
- R-type decode (opcode 6'h00), by funct; src2 = rt_data:
  - 20 add: ADD, ovf_en=1.
  - 21 addu: ADD, ovf_en=0.
  - 22 sub: SUB, ovf_en=1.
  - 23 subu: SUB, ovf_en=0.
  - 24 and: AND.
  - 25 or: OR.
  - 27 nor: NOR.
  - 2A slt: SLT.
- I-type decode, by opcode:
  - 08 addi: ADD, sign-extended imm, ovf_en=1.
  - 09 addiu: ADD, sign-extended imm.
  - 0A slti: SLT, sign-extended imm.
  - 0C andi: AND, zero-extended imm.
  - 0D ori: OR, zero-extended imm.
  - 23 lw, 2B sw: ADD, sign-extended imm.
  - 04 beq, 05 bne: SUB, src2 = rt_data.
- Any other opcode/funct:
  - illegal=1, alu_op=ADD, src2=rt_data, ovf_en=0.
  - The entry is still queued, not dropped.
- src1 is always rs_data. ovf_en=0 unless listed above.
- Decode is combinational on input. Push occurs when in_valid && in_ready && !flush; pop occurs when out_valid && out_ready.
- Latency: an op pushed in cycle N is visible at the outputs in cycle N+1. There is no same-cycle bypass.
- Outputs are driven from the head entry. When out_valid=0, alu_op, alu_src1, alu_src2, ovf_en and illegal are all driven to 0.
- Simultaneous push and pop when full:
  - Not permitted, because in_ready=0 when full.
  - When neither full nor empty, push and pop in the same cycle leave the count unchanged.
- Empty: out_valid=0; a pop attempt is a no-op.
- Full (count==DEPTH): in_ready=0; upstream must hold its inputs stable.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is log2(DEPTH)+1 bits.
- Flush is synchronous:
  - Next cycle, count=0, pointers=0, out_valid=0, in_ready=1.
  - Flush overrides a concurrent push and pop. The popped head is still consumed by the execute stage in the flush cycle.
- Reset (asynchronous, any time, including mid-transfer):
  - count=0, pointers=0, out_valid=0, in_ready=1, all data outputs 0.
  - Entry storage need not be cleared.
- Handshake stability: while out_valid=1 && out_ready=0, head outputs hold stable.

Decomposition:
- Shared package alu_pkg:
  - alu_op_t enum (AND, OR, ADD, SUB, SLT, NOR with the codes above).
  - Opcode and funct constants.
  - Struct issue_uop_t {alu_op, src1, src2, ovf_en, illegal}.
- One sub-module, alu_ctrl_decode: purely combinational; opcode/funct/imm16/rs_data/rt_data -> issue_uop_t.
- Top-level holds the FIFO storage, pointers, count and handshake.

Test Plan:
- Reset then push add (op 00/fn 20), rs=5, rt=3, out_ready=1 -> next cycle out_valid=1, alu_op=0010, src1=5, src2=3, ovf_en=1; following cycle out_valid=0.
- Push addiu imm16=16'hFFFF, then andi imm16=16'hFFFF -> first src2=32'hFFFFFFFF (sign-extended), second src2=32'h0000FFFF (zero-extended), alu_op 0010 then 0000.
- out_ready=0, push nor then slt -> count 2, in_ready=0; a third in_valid is not accepted. Raise out_ready -> ops emerge in order as 1100 then 0111; in_ready returns to 1 after the first pop.
- Push opcode 6'h3F -> out_valid=1, illegal=1, alu_op=0010, ovf_en=0.
- Fill 2 entries, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1; the incoming op is not queued.
- Assert rst asynchronously mid-cycle with 1 entry queued -> out_valid=0 and in_ready=1 immediately, without waiting for a clock edge; all data outputs are 0.
